// File: rtl/ecc_pkg.sv
// Shared constants and state encoding for the ECC core host bridge.
package ecc_pkg;
    localparam int WORD    = 32;
    localparam int NIB     = 4;
    localparam int NNIB    = WORD / NIB;
    localparam int TIMEOUT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        WAIT,
        RECV,
        RESP
    } state_t;
endpackage

// File: rtl/ecc_nibble_host_shifter.sv
// WORD-bit register: parallel load, NIB-wide shift toward the LSB end with din entering at the MSB end.
module nibble_shifter #(
    parameter int WORD = 32,
    parameter int NIB  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            load,
    input  logic [WORD-1:0] load_val,
    input  logic            shift,
    input  logic [NIB-1:0]  din,
    output logic [WORD-1:0] q
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   q <= '0;
        else if (load)  q <= load_val;
        else if (shift) q <= {din, q[WORD-1:NIB]};
    end
endmodule

// File: rtl/ecc_nibble_host.sv
// Host bridge for the nibble-serial ECC core: serializes one request, waits for done,
// collects the kP result nibbles and returns them over a valid/ready handshake.
module ecc_nibble_host
    import ecc_pkg::*;
#(
    parameter int WORD    = ecc_pkg::WORD,
    parameter int NIB     = ecc_pkg::NIB,
    parameter int TIMEOUT = ecc_pkg::TIMEOUT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [WORD-1:0] req_a,
    input  logic [WORD-1:0] req_prime,
    input  logic [WORD-1:0] req_k,
    input  logic [WORD-1:0] req_px,
    input  logic [WORD-1:0] req_py,
    output logic            o_start,
    output logic [NIB-1:0]  o_a,
    output logic [NIB-1:0]  o_prime,
    output logic [NIB-1:0]  o_k,
    output logic [NIB-1:0]  o_px,
    output logic [NIB-1:0]  o_py,
    input  logic            i_done,
    input  logic [NIB-1:0]  i_kpx,
    input  logic [NIB-1:0]  i_kpy,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [WORD-1:0] rsp_x,
    output logic [WORD-1:0] rsp_y,
    output logic            rsp_err
);
    localparam int NNIB = WORD / NIB;
    localparam int NB_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int NOPS = 5;

    state_t                    state, state_n;
    logic [NB_W-1:0]           nib_cnt;
    logic [TO_W-1:0]           to_cnt;
    logic [NOPS-1:0][WORD-1:0] op_in;
    logic [WORD-1:0]           op_q [NOPS];
    logic [NOPS-1:0][NIB-1:0]  o_nib;
    logic                      accept, nib_last, to_last, timeout_fire, send_n;
    logic                      unused_op;

    assign op_in        = {req_py, req_px, req_k, req_prime, req_a};
    assign {o_py, o_px, o_k, o_prime, o_a} = o_nib;
    assign accept       = (state == IDLE) && req_valid && req_ready;
    assign nib_last     = (nib_cnt == NB_W'(NNIB - 1));
    assign to_last      = (to_cnt == TO_W'(TIMEOUT - 1));
    // done has priority over an expiring timeout
    assign timeout_fire = (state == WAIT) && !i_done && to_last;
    assign send_n       = (state_n == SEND);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = START;
            START:   state_n = SEND;
            SEND:    if (nib_last) state_n = WAIT;
            WAIT:    if (i_done) state_n = RECV;
                     else if (to_last) state_n = RESP;
            RECV:    if (nib_last) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            nib_cnt   <= '0;
            to_cnt    <= '0;
            req_ready <= 1'b0;
            o_start   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            o_nib     <= '0;
        end else begin
            state     <= state_n;
            nib_cnt   <= ((state == SEND || state == RECV) && !nib_last) ? nib_cnt + 1'b1 : '0;
            to_cnt    <= (state == WAIT) ? to_cnt + 1'b1 : '0;
            req_ready <= (state_n == IDLE);
            o_start   <= (state_n == START);
            rsp_valid <= (state_n == RESP);
            rsp_err   <= (state_n == RESP) && (rsp_err || timeout_fire);
            for (int i = 0; i < NOPS; i++)
                o_nib[i] <= send_n ? op_q[i][NIB-1:0] : '0;
        end
    end

    for (genvar g = 0; g < NOPS; g++) begin : g_op
        nibble_shifter #(.WORD(WORD), .NIB(NIB)) u_sh (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .load     (accept),
            .load_val (op_in[g]),
            .shift    (send_n),
            .din      ('0),
            .q        (op_q[g])
        );
    end

    // Results are cleared on accept so a timeout returns zeros, never stale data.
    nibble_shifter #(.WORD(WORD), .NIB(NIB)) u_res_x (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .load     (accept),
        .load_val ('0),
        .shift    (state == RECV),
        .din      (i_kpx),
        .q        (rsp_x)
    );

    nibble_shifter #(.WORD(WORD), .NIB(NIB)) u_res_y (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .load     (accept),
        .load_val ('0),
        .shift    (state == RECV),
        .din      (i_kpy),
        .q        (rsp_y)
    );

    always_comb begin
        unused_op = 1'b0;
        for (int i = 0; i < NOPS; i++)
            unused_op = unused_op ^ (^op_q[i][WORD-1:NIB]);
    end
endmodule

// File: doc/ecc_nibble_host.md
# ecc_nibble_host

Host-side bridge for the nibble-serial ECC scalar-multiplication core (`Top_ting`).
- Accepts one 32-bit request word set (curve parameter `a`, `prime`, scalar `k`, point `Px`/`Py`) over a valid/ready handshake.
- Serializes the request onto the core's 4-bit input bus with a start pulse.
- Waits for the core's `done`, then deserializes the 8-nibble `kPx`/`kPy` result stream into 32-bit words.
- Returns the result over a second valid/ready handshake.
- Sits between the system-level request source and the ECC core. It is the driving/collecting end of the core's serial protocol.

## Interface
Parameters:
- `WORD` = 32: operand/result width.
- `NIB` = 4: serial nibble width; `WORD` must be a multiple of `NIB`.
- `TIMEOUT` = 4096: maximum cycles to wait for `i_done` after the last nibble is sent.

Ports:
- `i_clk`  in  1  single clock, all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request word set valid.
- `req_ready`  out  1  block idle and able to accept.
- `req_a`, `req_prime`, `req_k`, `req_px`, `req_py`  in  WORD each  request operands.
- `o_start`  out  1  one-cycle start pulse to core.
- `o_a`, `o_prime`, `o_k`, `o_px`, `o_py`  out  NIB each  serial operand nibbles.
- `i_done`  in  1  core completion pulse.
- `i_kpx`, `i_kpy`  in  NIB each  serial result nibbles.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_x`, `rsp_y`  out  WORD each  result point.
- `rsp_err`  out  1  result produced by timeout; `rsp_x`/`rsp_y` are 0.

## Operation
- NNIB = WORD/NIB (8). Nibble counter width is clog2(NNIB); timeout counter width is clog2(TIMEOUT+1).
- States and transitions:
  - IDLE: `req_ready`=1. Request accepted on `req_valid & req_ready`; operands latched into shift registers; go to START.
  - START: `o_start`=1 for exactly one cycle; nibble outputs 0; go to SEND.
  - SEND: NNIB cycles. Cycle n drives nibble n of each operand, LSB nibble first (bits [NIB*n+NIB-1 : NIB*n]). After nibble NNIB-1, go to WAIT with the timeout counter cleared.
  - WAIT:
    - Nibble outputs 0.
    - `i_done`=1: go to RECV.
    - Counter reaches TIMEOUT with no `i_done`: go to RESP with `rsp_err`=1 and zero results.
  - RECV: NNIB cycles. Cycle m after `done` (m=1..NNIB) samples `i_kpx`/`i_kpy` into result bits [NIB*(m-1)+NIB-1 : NIB*(m-1)]. After the last nibble, go to RESP.
  - RESP: `rsp_valid`=1. Outputs are held stable until `rsp_ready`; on the handshake go to IDLE.
- Boundary conditions:
  - `i_done` outside WAIT (during SEND, RECV, RESP, IDLE) is ignored.
  - `i_done` in the same cycle the timeout expires: `done` wins and goes to RECV.
  - `req_valid` while not idle is not accepted; there is no queueing.
  - The result registers are cleared on entry to START, so stale data is never returned.

## Timing
- Reset values: `req_ready`=0 while reset is asserted, 1 in the first cycle after deassertion. `o_start`=0. All nibble outputs=0. `rsp_valid`=0, `rsp_x`=`rsp_y`=0, `rsp_err`=0. State=IDLE; counters=0.
- Reset asserted mid-operation aborts immediately to IDLE. No response is produced.
- Request accept at cycle T gives:
  - `o_start` at T+1;
  - nibble n at T+2+n;
  - last nibble at T+1+NNIB;
  - WAIT from T+2+NNIB.
- `i_done` sampled at cycle D gives:
  - result nibble m sampled at D+m;
  - `rsp_valid` at D+NNIB+1.
- Every output is registered. No combinational path runs from `i_done`/`i_kp*` to outputs.
- Back-to-back: with `rsp_ready` held 1, `req_ready` returns 1 one cycle after the response handshake.

## Structure
- Shared package `ecc_pkg` holds:
  - the state enum (IDLE, START, SEND, WAIT, RECV, RESP);
  - the constants WORD, NIB, NNIB, and the default TIMEOUT.
- One natural sub-module, `nibble_shifter`: a parameterized WORD-bit register with parallel load, NIB-wide shift-out at the LSB end, and NIB-wide shift-in at the MSB end.
  - 5 instances for operands (shift-out).
  - 2 instances for results (shift-in).

## Test plan
- Serialization: `req_a`=0x12345678, `req_k`=0x0000_00A5, others 0.
  - `o_start` at T+1.
  - `o_a` = 8,7,6,5,4,3,2,1 on T+2..T+9.
  - `o_k` = 5,A,0,0,0,0,0,0 on T+2..T+9.
- Deserialization: core model pulses `i_done`, then drives `i_kpx` nibbles 0,5,0,0,0,0,0,0 and `i_kpy` nibbles A,0,0,…,0.
  - `rsp_x`=0x50 (80), `rsp_y`=0x0A (10), `rsp_err`=0.
  - This is the expected 2P for y²=x³+2x+3 mod 97 with P=(3,6), k=2.
- Backpressure: hold `rsp_ready`=0 for 20 cycles.
  - `rsp_valid`, `rsp_x`, `rsp_y` stay stable; `req_ready` stays 0.
  - Release `rsp_ready`: IDLE next cycle.
- Timeout: TIMEOUT=16, never assert `i_done`.
  - `rsp_valid` with `rsp_err`=1 and zero results, 16 cycles after WAIT entry.
- Spurious/simultaneous `done`:
  - `i_done` during SEND is ignored and the result is unaffected.
  - `i_done` coincident with the timeout expiry goes to RECV and gives `rsp_err`=0.
- Reset mid-RECV: drop `i_rst_n` at nibble 3.
  - All outputs take their reset values asynchronously; no `rsp_valid`.
  - The next request completes correctly.
